// File: rtl/clock_pkg.sv
// Shared timekeeping types: BCD digit widths, field limits and the packed
// HH:MM:SS record used by the counter, alarm register and comparator.
package clock_pkg;

  localparam int ONES_W     = 4;
  localparam int SEC_TENS_W = 3;
  localparam int MIN_TENS_W = 3;
  localparam int HR_TENS_W  = 2;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  typedef struct packed {
    logic [HR_TENS_W-1:0]  hr_tens;
    logic [ONES_W-1:0]     hr_ones;
    logic [MIN_TENS_W-1:0] min_tens;
    logic [ONES_W-1:0]     min_ones;
    logic [SEC_TENS_W-1:0] sec_tens;
    logic [ONES_W-1:0]     sec_ones;
  } bcd_time_t;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX; carry is combinational so
// the next field up can ripple on the same edge.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int TENS_W = 3,
  parameter int MAX    = 59
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [TENS_W-1:0] tens,
  output logic [ONES_W-1:0] ones,
  output logic              carry
);

  localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX / 10);
  localparam logic [ONES_W-1:0] MAX_O = ONES_W'(MAX % 10);

  logic at_max;

  // Wrap is decided on the full value, so 23 wraps even though ones < 9.
  assign at_max = (tens == MAX_T) && (ones == MAX_O);
  assign carry  = inc && at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= '0;
      ones <= '0;
    end else if (clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == ONES_W'(9)) begin
        tens <= tens + 1'b1;
        ones <= '0;
      end else begin
        ones <= ones + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour HH:MM:SS timekeeper: 1 Hz prescaler, set-pulse handling that
// pre-empts a coincident tick, and per-second / per-minute strobes.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  run,
  input  logic                  inc_min,
  input  logic                  inc_hr,
  input  logic                  clr_sec,
  output logic [HR_TENS_W-1:0]  hr_tens,
  output logic [ONES_W-1:0]     hr_ones,
  output logic [MIN_TENS_W-1:0] min_tens,
  output logic [ONES_W-1:0]     min_ones,
  output logic [SEC_TENS_W-1:0] sec_tens,
  output logic [ONES_W-1:0]     sec_ones,
  output logic                  sec_tick,
  output logic                  min_tick
);

  localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          tick, set_any, tick_ok;
  logic          sec_co, min_co, hr_co;
  logic          min_inc, hr_inc, min_tick_d;
  bcd_time_t     now;

  assign tick    = ena && run && (presc == PRESC_TC);
  assign set_any = ena && (inc_min || inc_hr || clr_sec);
  // A set pulse swallows a coincident tick; the prescaler still wraps.
  assign tick_ok = tick && !set_any;

  // Manual minute increments never carry into hours.
  assign min_inc    = sec_co || (ena && inc_min);
  assign hr_inc     = (sec_co && min_co) || (ena && inc_hr);
  assign min_tick_d = min_inc || hr_inc || hr_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (ena) begin
      if (clr_sec || !run || (presc == PRESC_TC)) presc <= '0;
      else                                         presc <= presc + 1'b1;
    end
  end

  bcd_mod_counter #(.TENS_W(SEC_TENS_W), .MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (tick_ok),
    .clr   (ena && clr_sec),
    .tens  (now.sec_tens),
    .ones  (now.sec_ones),
    .carry (sec_co)
  );

  bcd_mod_counter #(.TENS_W(MIN_TENS_W), .MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .tens  (now.min_tens),
    .ones  (now.min_ones),
    .carry (min_co)
  );

  bcd_mod_counter #(.TENS_W(HR_TENS_W), .MAX(HR_MAX)) u_hr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hr_inc),
    .clr   (1'b0),
    .tens  (now.hr_tens),
    .ones  (now.hr_ones),
    .carry (hr_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_tick <= 1'b0;
      min_tick <= 1'b0;
    end else begin
      sec_tick <= tick_ok;
      min_tick <= min_tick_d;
    end
  end

  assign hr_tens  = now.hr_tens;
  assign hr_ones  = now.hr_ones;
  assign min_tens = now.min_tens;
  assign min_ones = now.min_ones;
  assign sec_tens = now.sec_tens;
  assign sec_ones = now.sec_ones;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with CLK_HZ=10; expected times are
// hand-computed HH:MM:SS values packed in digit order.
module tb_time_of_day_counter;

  localparam int HZ = 10;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, run = 1'b0;
  logic       inc_min = 1'b0, inc_hr = 1'b0, clr_sec = 1'b0;
  logic [1:0] hr_tens;
  logic [3:0] hr_ones, min_ones, sec_ones;
  logic [2:0] min_tens, sec_tens;
  logic       sec_tick, min_tick;

  int errors = 0;
  int checks = 0;
  int st, mt;

  always #5 clk = ~clk;

  time_of_day_counter #(.CLK_HZ(HZ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .run      (run),
    .inc_min  (inc_min),
    .inc_hr   (inc_hr),
    .clr_sec  (clr_sec),
    .hr_tens  (hr_tens),
    .hr_ones  (hr_ones),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .sec_tick (sec_tick),
    .min_tick (min_tick)
  );

  wire [19:0] cur = {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};

  function automatic logic [19:0] hms(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_n(input int n, output int s_cnt, output int m_cnt);
    s_cnt = 0;
    m_cnt = 0;
    repeat (n) begin
      step();
      s_cnt += int'(sec_tick);
      m_cnt += int'(min_tick);
    end
  endtask

  task automatic pulses(input logic m, input logic h, input logic c, input int n,
                        output int s_cnt, output int m_cnt);
    inc_min = m;
    inc_hr  = h;
    clr_sec = c;
    run_n(n, s_cnt, m_cnt);
    inc_min = 1'b0;
    inc_hr  = 1'b0;
    clr_sec = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    run = 1'b1;
    inc_min = 1'b0;
    inc_hr = 1'b0;
    clr_sec = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ena = 1'b1;
    run = 1'b1;
    step();
    checks++; if (cur !== 20'd0) begin errors++; $display("FAIL reset_time got %h want %h", cur, 20'd0); end
    checks++; if (sec_tick !== 1'b0) begin errors++; $display("FAIL reset_sec_tick got %b want 0", sec_tick); end
    checks++; if (min_tick !== 1'b0) begin errors++; $display("FAIL reset_min_tick got %b want 0", min_tick); end
    rst_n = 1'b1;
    run_n(9, st, mt);
    checks++; if (st != 0) begin errors++; $display("FAIL reset_early_tick got %0d want 0", st); end
    step();
    checks++; if (sec_tick !== 1'b1) begin errors++; $display("FAIL reset_first_tick got %b want 1", sec_tick); end
    checks++; if (cur !== hms(0, 0, 1)) begin errors++; $display("FAIL reset_first_time got %h want %h", cur, hms(0, 0, 1)); end
    checks++; if (min_tick !== 1'b0) begin errors++; $display("FAIL reset_first_min_tick got %b want 0", min_tick); end
  endtask

  task automatic test_preload_wrap();
    do_reset();
    run = 1'b0;
    pulses(1'b0, 1'b1, 1'b0, 23, st, mt);
    checks++; if (mt != 23) begin errors++; $display("FAIL preload_hr_min_ticks got %0d want 23", mt); end
    checks++; if (cur !== hms(23, 0, 0)) begin errors++; $display("FAIL preload_hr got %h want %h", cur, hms(23, 0, 0)); end
    pulses(1'b1, 1'b0, 1'b0, 59, st, mt);
    checks++; if (mt != 59) begin errors++; $display("FAIL preload_min_ticks got %0d want 59", mt); end
    checks++; if (cur !== hms(23, 59, 0)) begin errors++; $display("FAIL preload_min got %h want %h", cur, hms(23, 59, 0)); end
    run = 1'b1;
    run_n(580, st, mt);
    checks++; if (st != 58 || mt != 0) begin errors++; $display("FAIL preload_run_ticks got sec=%0d min=%0d want 58 0", st, mt); end
    checks++; if (cur !== hms(23, 59, 58)) begin errors++; $display("FAIL preload_run got %h want %h", cur, hms(23, 59, 58)); end
    run_n(9, st, mt);
    step();
    checks++; if (st != 0 || sec_tick !== 1'b1) begin errors++; $display("FAIL wrap_tick59 got early=%0d tick=%b want 0 1", st, sec_tick); end
    checks++; if (cur !== hms(23, 59, 59)) begin errors++; $display("FAIL wrap_59 got %h want %h", cur, hms(23, 59, 59)); end
    run_n(9, st, mt);
    checks++; if (st != 0 || mt != 0) begin errors++; $display("FAIL wrap_quiet got sec=%0d min=%0d want 0 0", st, mt); end
    step();
    checks++; if (cur !== 20'd0) begin errors++; $display("FAIL wrap_midnight got %h want %h", cur, 20'd0); end
    checks++; if (min_tick !== 1'b1 || sec_tick !== 1'b1) begin errors++; $display("FAIL wrap_strobes got min=%b sec=%b want 1 1", min_tick, sec_tick); end
    step();
    checks++; if (min_tick !== 1'b0) begin errors++; $display("FAIL wrap_min_tick_width got %b want 0", min_tick); end
  endtask

  task automatic test_set_mode();
    do_reset();
    run = 1'b0;
    pulses(1'b1, 1'b0, 1'b0, 61, st, mt);
    checks++; if (mt != 61 || st != 0) begin errors++; $display("FAIL set_min61_ticks got min=%0d sec=%0d want 61 0", mt, st); end
    checks++; if (cur !== hms(0, 1, 0)) begin errors++; $display("FAIL set_min61 got %h want %h", cur, hms(0, 1, 0)); end
    pulses(1'b1, 1'b1, 1'b0, 1, st, mt);
    checks++; if (cur !== hms(1, 2, 0) || mt != 1) begin errors++; $display("FAIL set_both got %h mt=%0d want %h 1", cur, mt, hms(1, 2, 0)); end
    pulses(1'b0, 1'b0, 1'b1, 1, st, mt);
    checks++; if (cur !== hms(1, 2, 0) || mt != 0) begin errors++; $display("FAIL set_clr_only got %h mt=%0d want %h 0", cur, mt, hms(1, 2, 0)); end
    pulses(1'b0, 1'b1, 1'b0, 23, st, mt);
    checks++; if (cur !== hms(0, 2, 0)) begin errors++; $display("FAIL set_hr_wrap got %h want %h", cur, hms(0, 2, 0)); end
  endtask

  task automatic test_set_on_tick();
    do_reset();
    run_n(9, st, mt);
    inc_min = 1'b1;
    step();
    inc_min = 1'b0;
    checks++; if (cur !== hms(0, 1, 0)) begin errors++; $display("FAIL tc_inc_time got %h want %h", cur, hms(0, 1, 0)); end
    checks++; if (sec_tick !== 1'b0 || min_tick !== 1'b1) begin errors++; $display("FAIL tc_inc_strobes got sec=%b min=%b want 0 1", sec_tick, min_tick); end
    run_n(9, st, mt);
    step();
    checks++; if (st != 0 || sec_tick !== 1'b1) begin errors++; $display("FAIL tc_next_tick got early=%0d tick=%b want 0 1", st, sec_tick); end
    checks++; if (cur !== hms(0, 1, 1)) begin errors++; $display("FAIL tc_next_time got %h want %h", cur, hms(0, 1, 1)); end
  endtask

  task automatic test_clr_sec();
    do_reset();
    run = 1'b0;
    pulses(1'b0, 1'b1, 1'b0, 12, st, mt);
    pulses(1'b1, 1'b0, 1'b0, 34, st, mt);
    run = 1'b1;
    run_n(560, st, mt);
    checks++; if (cur !== hms(12, 34, 56)) begin errors++; $display("FAIL clr_setup got %h want %h", cur, hms(12, 34, 56)); end
    run_n(7, st, mt);
    clr_sec = 1'b1;
    step();
    clr_sec = 1'b0;
    checks++; if (cur !== hms(12, 34, 0)) begin errors++; $display("FAIL clr_time got %h want %h", cur, hms(12, 34, 0)); end
    checks++; if (sec_tick !== 1'b0 || min_tick !== 1'b0) begin errors++; $display("FAIL clr_strobes got sec=%b min=%b want 0 0", sec_tick, min_tick); end
    run_n(9, st, mt);
    step();
    checks++; if (st != 0 || sec_tick !== 1'b1) begin errors++; $display("FAIL clr_next_tick got early=%0d tick=%b want 0 1", st, sec_tick); end
    checks++; if (cur !== hms(12, 34, 1)) begin errors++; $display("FAIL clr_next_time got %h want %h", cur, hms(12, 34, 1)); end
  endtask

  task automatic test_reset_mid_and_ena();
    do_reset();
    run = 1'b0;
    pulses(1'b0, 1'b1, 1'b0, 5, st, mt);
    pulses(1'b1, 1'b0, 1'b0, 6, st, mt);
    run = 1'b1;
    run_n(70, st, mt);
    checks++; if (cur !== hms(5, 6, 7)) begin errors++; $display("FAIL mid_setup got %h want %h", cur, hms(5, 6, 7)); end
    run_n(4, st, mt);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (cur !== 20'd0) begin errors++; $display("FAIL mid_async_clear got %h want %h", cur, 20'd0); end
    step();
    rst_n = 1'b1;
    run_n(9, st, mt);
    step();
    checks++; if (st != 0 || sec_tick !== 1'b1) begin errors++; $display("FAIL mid_restart_tick got early=%0d tick=%b want 0 1", st, sec_tick); end
    checks++; if (cur !== hms(0, 0, 1)) begin errors++; $display("FAIL mid_restart_time got %h want %h", cur, hms(0, 0, 1)); end
    run_n(3, st, mt);
    ena = 1'b0;
    pulses(1'b1, 1'b0, 1'b0, 20, st, mt);
    checks++; if (st != 0 || mt != 0) begin errors++; $display("FAIL ena_off_strobes got sec=%0d min=%0d want 0 0", st, mt); end
    checks++; if (cur !== hms(0, 0, 1)) begin errors++; $display("FAIL ena_off_time got %h want %h", cur, hms(0, 0, 1)); end
    ena = 1'b1;
    run_n(6, st, mt);
    step();
    checks++; if (st != 0 || sec_tick !== 1'b1) begin errors++; $display("FAIL ena_resume_tick got early=%0d tick=%b want 0 1", st, sec_tick); end
    checks++; if (cur !== hms(0, 0, 2)) begin errors++; $display("FAIL ena_resume_time got %h want %h", cur, hms(0, 0, 2)); end
  endtask

  initial begin
    test_reset();
    test_preload_wrap();
    test_set_mode();
    test_set_on_tick();
    test_clr_sec();
    test_reset_mid_and_ena();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
